// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencing controller.
// One state per pipeline phase, with ready handshakes to both memories.
module multicycle_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [6:0]           opcode,
    input  logic                 alu_check,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t     st;
    logic [6:0] op_q;

    logic is_r, is_i, is_ld, is_st, is_br;
    logic is_jal, is_jalr, is_lui, is_auipc;
    logic id_legal;

    assign is_r     = (op_q == OP_R);
    assign is_i     = (op_q == OP_I);
    assign is_ld    = (op_q == OP_LOAD);
    assign is_st    = (op_q == OP_STORE);
    assign is_br    = (op_q == OP_BR);
    assign is_jal   = (op_q == OP_JAL);
    assign is_jalr  = (op_q == OP_JALR);
    assign is_lui   = (op_q == OP_LUI);
    assign is_auipc = (op_q == OP_AUIPC);

    always_comb begin
        id_legal = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
                id_legal = 1'b1;
            default:
                id_legal = 1'b0;
        endcase
    end

    assign state = st;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st      <= S_IF;
            op_q    <= '0;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            case (st)
                S_IF: begin
                    if (imem_ready)
                        st <= S_ID;
                end
                S_ID: begin
                    op_q <= opcode;
                    if (id_legal) begin
                        st <= S_EX;
                    end else begin
                        st      <= S_ERR;
                        illegal <= 1'b1;
                    end
                end
                S_EX: begin
                    if (is_ld || is_st) begin
                        st <= S_MEM;
                    end else if (is_br || is_jal || is_jalr) begin
                        st      <= S_IF;
                        instret <= instret + ONE;
                    end else begin
                        st <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (is_st) begin
                            st      <= S_IF;
                            instret <= instret + ONE;
                        end else begin
                            st <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    st      <= S_IF;
                    instret <= instret + ONE;
                end
                S_ERR: st <= S_ERR;
                default: st <= S_IF;
            endcase
        end
    end

    // ALU selects chosen in EX, reused in WB so the result stays valid
    logic       ex_a;
    logic [1:0] ex_b;
    logic [1:0] ex_op;

    always_comb begin
        ex_a  = 1'b0;
        ex_b  = 2'b00;
        ex_op = 2'b00;
        unique case (1'b1)
            is_r:          ex_op = 2'b10;
            is_i:          begin ex_b = 2'b01; ex_op = 2'b10; end
            is_ld, is_st:  ex_b = 2'b01;
            is_lui:        begin ex_b = 2'b01; ex_op = 2'b11; end
            is_auipc:      begin ex_a = 1'b1; ex_b = 2'b01; end
            is_br:         ex_op = 2'b01;
            is_jalr:       ex_b = 2'b01;
            default:       ex_b = 2'b00;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        case (st)
            S_IF: begin
                imem_req  = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ir_write  = imem_ready;
                pc_write  = imem_ready;
            end
            S_EX: begin
                alu_src_a = ex_a;
                alu_src_b = ex_b;
                alu_op    = ex_op;
                if (is_br) begin
                    pc_src   = 2'b01;
                    pc_write = alu_check;
                end
                if (is_jal) begin
                    pc_src    = 2'b01;
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                    wb_sel    = 2'b10;
                end
                if (is_jalr) begin
                    pc_src    = 2'b10;
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                    wb_sel    = 2'b10;
                end
            end
            S_MEM: begin
                alu_src_b = 2'b01;
                mem_read  = is_ld;
                mem_write = is_st;
            end
            S_WB: begin
                alu_src_a = ex_a;
                alu_src_b = ex_b;
                alu_op    = ex_op;
                reg_write = 1'b1;
                wb_sel    = is_ld ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
        if (!rstn) begin
            imem_req  = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule
